// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Purpose  : Oversampled I2C target with a byte register file, pointer and
//            auto-increment for multi-byte reads and writes.
// Revision : 1.0
// ============================================================================
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic                  wr_pulse,
    output logic [PTR_W-1:0]      wr_addr,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK      = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    localparam logic [PTR_W-1:0] c_PTR_MAX = PTR_W'(NUM_REGS - 1);
    localparam logic [8:0]       c_NREGS9  = 9'(NUM_REGS);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_cnt, w_cnt_nxt;
    logic [7:0]             r_shift, w_shift_nxt;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt;
    logic                   r_oe, w_oe_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_rw, w_rw_nxt;
    logic                   w_wr_en;
    logic                   r_wr_pulse;
    logic [PTR_W-1:0]       r_wr_addr;
    logic [7:0]             r_regs [NUM_REGS];

    logic                   w_scl, w_sda;
    logic                   w_scl_rise, w_scl_fall;
    logic                   w_start, w_stop;
    logic [7:0]             w_byte;
    logic [7:0]             w_rd_byte;
    logic [PTR_W-1:0]       w_ptr_inc;
    logic                   w_ptr_ok;

    // Bus idles high, so the synchronisers reset to 1 to avoid false edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];
    assign w_ptr_inc = (r_ptr == c_PTR_MAX) ? '0 : r_ptr + 1'b1;
    assign w_ptr_ok  = ({1'b0, w_byte} < c_NREGS9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_oe       <= w_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_rw       <= w_rw_nxt;
            r_wr_pulse <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    // A bit count of 8 marks a completed byte waiting for the SCL fall that
    // opens its acknowledge slot.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_oe;
        w_busy_nxt  = r_busy;
        w_rw_nxt    = r_rw;
        w_wr_en     = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise && r_cnt != 4'd8) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (r_state == S_ADDR) begin
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    w_rw_nxt   = w_byte[0];
                                    w_busy_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = S_IGNORE;
                                    w_busy_nxt  = 1'b0;
                                end
                            end else if (r_state == S_PTR) begin
                                if (w_ptr_ok) begin
                                    w_ptr_nxt = w_byte[PTR_W-1:0];
                                end else begin
                                    w_state_nxt = S_IGNORE;
                                    w_busy_nxt  = 1'b0;
                                end
                            end else begin
                                w_wr_en   = 1'b1;
                                w_ptr_nxt = w_ptr_inc;
                            end
                        end
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_cnt_nxt = '0;
                        w_oe_nxt  = 1'b1;
                        if (r_state == S_ADDR) begin
                            w_state_nxt = S_ADDR_ACK;
                        end else if (r_state == S_PTR) begin
                            w_state_nxt = S_PTR_ACK;
                        end else begin
                            w_state_nxt = S_WDATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            w_shift_nxt = w_rd_byte;
                            w_oe_nxt    = ~w_rd_byte[7];
                            w_ptr_nxt   = w_ptr_inc;
                            w_state_nxt = S_RDATA;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = S_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt   = '0;
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = S_RACK;
                        end else begin
                            w_cnt_nxt   = r_cnt + 4'd1;
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oe_nxt    = ~r_shift[6];
                        end
                    end
                end
                S_RACK: begin
                    if (w_scl_rise && r_cnt != 4'd8) begin
                        if (w_sda) begin
                            w_state_nxt = S_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_cnt_nxt = 4'd8;
                        end
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_cnt_nxt   = '0;
                        w_shift_nxt = w_rd_byte;
                        w_oe_nxt    = ~w_rd_byte[7];
                        w_ptr_nxt   = w_ptr_inc;
                        w_state_nxt = S_RDATA;
                    end
                end
                default: begin
                    w_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regq
            assign reg_q[8*gi +: 8] = r_regs[gi];
        end
    endgenerate

    assign sda      = r_oe ? 1'b0 : 1'bz;
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Purpose  : Table-driven and randomized bench for i2c_slave_regfile.
// Revision : 1.0
// ============================================================================
module tb_i2c_slave_regfile;

    localparam int NREG = 16;
    localparam int HALF = 8;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              scl  = 1'b1;
    logic              m_oe = 1'b0;
    wire               sda;
    logic [NREG*8-1:0] reg_q;
    logic              wr_pulse;
    logic [3:0]        wr_addr;
    logic              busy;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h50),
        .NUM_REGS   (NREG),
        .PTR_W      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda),
        .reg_q   (reg_q),
        .wr_pulse(wr_pulse),
        .wr_addr (wr_addr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] q_wr[$];
    logic       busy_seen = 1'b0;
    logic [7:0] mdl_mem [NREG];
    int         mdl_ptr;

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) q_wr.push_back(wr_addr);
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        m_oe = 1'b0; wclk(4); scl = 1'b1; wclk(HALF);
        m_oe = 1'b1; wclk(HALF); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        m_oe = 1'b1; wclk(4); scl = 1'b1; wclk(HALF);
        m_oe = 1'b0; wclk(HALF);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            wclk(2); m_oe = ~b[i]; wclk(HALF-2);
            scl = 1'b1; wclk(HALF); scl = 1'b0;
        end
        wclk(2); m_oe = 1'b0; wclk(HALF-2);
        scl = 1'b1; wclk(4); ack = (sda === 1'b0); wclk(HALF-4); scl = 1'b0;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_oe = 1'b0; wclk(HALF);
            scl = 1'b1; wclk(4); b[i] = (sda === 1'b1); wclk(HALF-4); scl = 1'b0;
        end
        wclk(2); m_oe = mack; wclk(HALF-2);
        scl = 1'b1; wclk(HALF); scl = 1'b0;
        m_oe = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] p, input int n,
                            input logic [31:0] data, output logic [5:0] acks);
        logic a;
        acks = '0;
        i2c_start;
        wr_byte(ab, a); acks[0] = a;
        wr_byte(p, a);  acks[1] = a;
        for (int k = 0; k < n; k++) begin
            wr_byte(data[8*k +: 8], a); acks[2+k] = a;
        end
        i2c_stop;
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n,
                           output logic [31:0] rd, output logic [5:0] acks);
        logic a;
        logic [7:0] b;
        acks = '0;
        rd   = '0;
        i2c_start;
        if (set_ptr) begin
            wr_byte(8'hA0, a); acks[0] = a;
            wr_byte(p, a);     acks[1] = a;
            i2c_start;
        end
        wr_byte(8'hA1, a); acks[2] = a;
        for (int k = 0; k < n; k++) begin
            rd_byte(k != n-1, b);
            rd[8*k +: 8] = b;
        end
        wclk(6);
        chk("sda_released_after_nack", {127'd0, sda}, 128'd1);
        i2c_stop;
    endtask

    typedef struct {
        logic        is_read;
        logic        set_ptr;
        logic [7:0]  ab;
        logic [7:0]  p;
        int          n;
        logic [31:0] data;
        logic [5:0]  exp_acks;
        int          exp_np;
        int          exp_pa0;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [5:0]   acks;
        logic [31:0]  rd;
        logic [127:0] exp_q;
        logic         a;

        vecs[0] = '{1'b0, 1'b0, 8'hA0, 8'h03, 2, 32'h0000_5AA5, 6'b001111, 2, 3,  32'h0};
        vecs[1] = '{1'b1, 1'b1, 8'hA1, 8'h03, 2, 32'h0,         6'b000111, 0, 0,  32'h0000_5AA5};
        vecs[2] = '{1'b0, 1'b0, 8'hA2, 8'h00, 1, 32'h0000_00FF, 6'b000000, 0, 0,  32'h0};
        vecs[3] = '{1'b0, 1'b0, 8'hA0, 8'h0F, 3, 32'h0033_2211, 6'b011111, 3, 15, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 8'hA1, 8'h00, 1, 32'h0,         6'b000100, 0, 0,  32'h0000_0000};
        vecs[5] = '{1'b0, 1'b0, 8'hA0, 8'h20, 1, 32'h0000_0099, 6'b000001, 0, 0,  32'h0};
        vecs[6] = '{1'b1, 1'b0, 8'hA1, 8'h00, 1, 32'h0,         6'b000100, 0, 0,  32'h0000_00A5};
        vecs[7] = '{1'b1, 1'b1, 8'hA1, 8'h0F, 3, 32'h0,         6'b000111, 0, 0,  32'h0033_2211};

        wclk(3);
        rst = 1'b0;
        wclk(6);
        chk("reset_reg_q", reg_q, '0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_wr_pulse", {127'd0, wr_pulse}, 128'd0);
        chk("reset_wr_addr", {124'd0, wr_addr}, 128'd0);
        chk("reset_sda", {127'd0, sda}, 128'd1);

        for (int v = 0; v < 8; v++) begin
            q_wr.delete();
            busy_seen = 1'b0;
            if (vecs[v].is_read)
                do_read(vecs[v].set_ptr, vecs[v].p, vecs[v].n, rd, acks);
            else
                do_write(vecs[v].ab, vecs[v].p, vecs[v].n, vecs[v].data, acks);
            wclk(4);
            chk($sformatf("vec%0d_acks", v), {122'd0, acks}, {122'd0, vecs[v].exp_acks});
            if (vecs[v].is_read)
                chk($sformatf("vec%0d_rdata", v), {96'd0, rd}, {96'd0, vecs[v].exp_rd});
            chk($sformatf("vec%0d_npulse", v), 128'(q_wr.size()), 128'(vecs[v].exp_np));
            for (int k = 0; k < q_wr.size() && k < vecs[v].exp_np; k++)
                chk($sformatf("vec%0d_wr_addr%0d", v, k), {124'd0, q_wr[k]},
                    128'((vecs[v].exp_pa0 + k) % NREG));
            chk($sformatf("vec%0d_busy_after", v), {127'd0, busy}, 128'd0);
            chk($sformatf("vec%0d_busy_seen", v), {127'd0, busy_seen},
                {127'd0, vecs[v].exp_acks[0] | vecs[v].exp_acks[2]});
        end

        exp_q = '0;
        exp_q[8*3 +: 8]  = 8'hA5;
        exp_q[8*4 +: 8]  = 8'h5A;
        exp_q[8*15 +: 8] = 8'h11;
        exp_q[8*0 +: 8]  = 8'h22;
        exp_q[8*1 +: 8]  = 8'h33;
        chk("table_reg_q", reg_q, exp_q);

        // Reset while the slave holds SDA low for bit 7 of reg0 (0x22).
        i2c_start;
        wr_byte(8'hA0, a);
        wr_byte(8'h00, a);
        i2c_start;
        wr_byte(8'hA1, a);
        wclk(5);
        chk("rdata_sda_driven_low", {127'd0, sda}, 128'd0);
        rst = 1'b1;
        #1;
        chk("rst_sda_released", {127'd0, sda}, 128'd1);
        chk("rst_reg_q", reg_q, '0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_wr_addr", {124'd0, wr_addr}, 128'd0);
        wclk(2);
        scl  = 1'b1;
        m_oe = 1'b0;
        wclk(4);
        rst = 1'b0;
        wclk(6);
        chk("post_rst_busy_idle", {127'd0, busy}, 128'd0);
        i2c_start;
        wr_byte(8'hA0, a);
        chk("post_rst_addr_ack", {127'd0, a}, 128'd1);
        i2c_stop;

        for (int i = 0; i < NREG; i++) mdl_mem[i] = 8'h00;
        mdl_ptr = 0;
        for (int t = 0; t < 24; t++) begin
            int          kind, n, p;
            logic [31:0] data, exp_rd;
            logic [5:0]  exp_acks;
            int          exp_addr [$];
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            data = $urandom;
            q_wr.delete();
            exp_addr.delete();
            exp_rd = '0;
            if (kind == 0) begin
                p = $urandom_range(0, NREG-1);
                do_write(8'hA0, 8'(p), n, data, acks);
                exp_acks = 6'((1 << (n + 2)) - 1);
                mdl_ptr = p;
                for (int k = 0; k < n; k++) begin
                    mdl_mem[mdl_ptr] = data[8*k +: 8];
                    exp_addr.push_back(mdl_ptr);
                    mdl_ptr = (mdl_ptr + 1) % NREG;
                end
            end else if (kind == 3) begin
                p = $urandom_range(NREG, 255);
                do_write(8'hA0, 8'(p), 1, data, acks);
                exp_acks = 6'b000001;
            end else begin
                p = $urandom_range(0, NREG-1);
                do_read(kind == 1, 8'(p), n, rd, acks);
                exp_acks = (kind == 1) ? 6'b000111 : 6'b000100;
                if (kind == 1) mdl_ptr = p;
                for (int k = 0; k < n; k++) begin
                    exp_rd[8*k +: 8] = mdl_mem[mdl_ptr];
                    mdl_ptr = (mdl_ptr + 1) % NREG;
                end
                chk($sformatf("rnd%0d_rdata", t), {96'd0, rd}, {96'd0, exp_rd});
            end
            wclk(4);
            chk($sformatf("rnd%0d_acks", t), {122'd0, acks}, {122'd0, exp_acks});
            chk($sformatf("rnd%0d_npulse", t), 128'(q_wr.size()), 128'(exp_addr.size()));
            for (int k = 0; k < q_wr.size() && k < exp_addr.size(); k++)
                chk($sformatf("rnd%0d_wr_addr%0d", t, k), {124'd0, q_wr[k]}, 128'(exp_addr[k]));
            exp_q = '0;
            for (int i = 0; i < NREG; i++) exp_q[8*i +: 8] = mdl_mem[i];
            chk($sformatf("rnd%0d_reg_q", t), reg_q, exp_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
